counter_game_referee: RTL and testbench

Control-side partner of the multi-mode counter. It drives the counter's `ctrlBus`, `initValue` and `INIT` inputs, and consumes its `WINNER`, `LOSER`, `GAMEOVER`, `WHO` and `count` outputs. It sequences a game:

- loads a seed;
- runs the counter for a programmable number of cycles per round;
- reverses the count direction at each round boundary;
- keeps saturating win/lose tallies;
- declares a champion when the counter reports game over or a tally saturates.

---
 rtl/counter_game_pkg.sv | 33 +++
 rtl/counter_game_referee_sat_tally.sv | 37 +++
 rtl/counter_game_referee.sv | 147 ++++++++++++++
 tb/tb_counter_game_referee.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_game_pkg.sv
// Shared types and constants for the counter game referee and its tally sub-block.
package counter_game_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StDone
    } state_e;

    localparam logic [1:0] MODE_UP1 = 2'b00;
    localparam logic [1:0] MODE_UP2 = 2'b01;
    localparam logic [1:0] MODE_DN1 = 2'b10;
    localparam logic [1:0] MODE_DN2 = 2'b11;

    localparam logic [1:0] CHAMP_NONE   = 2'b00;
    localparam logic [1:0] CHAMP_LOSER  = 2'b01;
    localparam logic [1:0] CHAMP_WINNER = 2'b10;
    localparam logic [1:0] CHAMP_DRAW   = 2'b11;

    // Reverse the count direction while keeping the step size.
    function automatic logic [1:0] mode_flip(input logic [1:0] mode);
        logic [1:0] flipped;
        unique case (mode)
            MODE_UP1: flipped = MODE_DN1;
            MODE_UP2: flipped = MODE_DN2;
            MODE_DN1: flipped = MODE_UP1;
            default:  flipped = MODE_UP2;
        endcase
        return flipped;
    endfunction

endpackage

// File: rtl/counter_game_referee_sat_tally.sv
// Saturating score counter; at_max flags that this edge's increment lands on the maximum.
module sat_tally #(
    parameter int unsigned SCORE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               inc,
    output logic [SCORE_W-1:0] value,
    output logic               at_max
);

    localparam logic [SCORE_W-1:0] MAX = '1;

    logic [SCORE_W-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc && (value_q != MAX)) begin
            value_d = value_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value  = value_q;
    assign at_max = inc && !clr && (value_q == MAX - 1'b1);

endmodule

// File: rtl/counter_game_referee.sv
// Game sequencer driving the multi-mode counter: seed load, timed direction flips,
// win/lose tallies and champion declaration.
module counter_game_referee
    import counter_game_pkg::*;
#(
    parameter int unsigned RUN_CYCLES = 16,
    parameter int unsigned SCORE_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         mode_req,
    input  logic [3:0]         seed,
    input  logic               winner,
    input  logic               loser,
    input  logic               gameover,
    input  logic [1:0]         who,
    input  logic [3:0]         count,
    output logic [1:0]         ctrl_bus,
    output logic [3:0]         init_value,
    output logic               init,
    output logic [SCORE_W-1:0] win_tally,
    output logic [SCORE_W-1:0] lose_tally,
    output logic               busy,
    output logic               done,
    output logic [1:0]         champion
);

    localparam int unsigned         TIMER_W    = $clog2(RUN_CYCLES);
    localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(RUN_CYCLES - 1);

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [1:0]         ctrl_q, ctrl_d;
    logic [1:0]         champ_q, champ_d;
    logic [3:0]         initv_q, initv_d;
    logic               init_q, busy_q, done_q;

    logic tally_clr, win_inc, lose_inc, win_hit, lose_hit;

    // The counter value is observed for monitoring only.
    logic unused_count;
    assign unused_count = ^count;

    assign win_inc  = winner && (state_q == StRun);
    assign lose_inc = loser && (state_q == StRun);

    sat_tally #(
        .SCORE_W(SCORE_W)
    ) u_win_tally (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tally_clr),
        .inc   (win_inc),
        .value (win_tally),
        .at_max(win_hit)
    );

    sat_tally #(
        .SCORE_W(SCORE_W)
    ) u_lose_tally (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tally_clr),
        .inc   (lose_inc),
        .value (lose_tally),
        .at_max(lose_hit)
    );

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        ctrl_d    = ctrl_q;
        champ_d   = champ_q;
        initv_d   = initv_q;
        tally_clr = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d   = StLoad;
                    ctrl_d    = mode_req;
                    initv_d   = seed;
                    champ_d   = CHAMP_NONE;
                    timer_d   = '0;
                    tally_clr = 1'b1;
                end
            end
            StLoad: begin
                state_d = StRun;
            end
            StRun: begin
                if (gameover) begin
                    state_d = StDone;
                    champ_d = who;
                end else if (win_hit || lose_hit) begin
                    state_d = StDone;
                    if (win_hit && lose_hit) begin
                        champ_d = CHAMP_DRAW;
                    end else if (win_hit) begin
                        champ_d = CHAMP_WINNER;
                    end else begin
                        champ_d = CHAMP_LOSER;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    ctrl_d  = mode_flip(ctrl_q);
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            timer_q <= '0;
            ctrl_q  <= '0;
            champ_q <= '0;
            initv_q <= '0;
            init_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ctrl_q  <= ctrl_d;
            champ_q <= champ_d;
            initv_q <= initv_d;
            init_q  <= (state_d == StLoad);
            busy_q  <= (state_d == StLoad) || (state_d == StRun);
            done_q  <= (state_d == StDone);
        end
    end

    assign ctrl_bus   = ctrl_q;
    assign init_value = initv_q;
    assign init       = init_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign champion   = champ_q;

endmodule

// File: tb/tb_counter_game_referee.sv
// Randomised and scenario-driven bench for counter_game_referee against a behavioural game model.
module tb_counter_game_referee;

    localparam int RC  = 4;
    localparam int MAX = 15;

    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_RUN  = 2;
    localparam int PH_DONE = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] mode_req = '0;
    logic [3:0] seed = '0;
    logic       winner = 1'b0;
    logic       loser = 1'b0;
    logic       gameover = 1'b0;
    logic [1:0] who = '0;
    logic [3:0] count = '0;
    logic [1:0] ctrl_bus;
    logic [3:0] init_value;
    logic       init;
    logic [3:0] win_tally;
    logic [3:0] lose_tally;
    logic       busy;
    logic       done;
    logic [1:0] champion;

    counter_game_referee #(
        .RUN_CYCLES(RC),
        .SCORE_W   (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode_req  (mode_req),
        .seed      (seed),
        .winner    (winner),
        .loser     (loser),
        .gameover  (gameover),
        .who       (who),
        .count     (count),
        .ctrl_bus  (ctrl_bus),
        .init_value(init_value),
        .init      (init),
        .win_tally (win_tally),
        .lose_tally(lose_tally),
        .busy      (busy),
        .done      (done),
        .champion  (champion)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Game model: phase, captured mode/seed, tallies, champion, non-exit run cycles.
    int       m_phase;
    bit [1:0] m_mode;
    int       m_iv;
    int       m_w;
    int       m_l;
    int       m_champ;
    int       m_runs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_IDLE;
        m_mode  = '0;
        m_iv    = 0;
        m_w     = 0;
        m_l     = 0;
        m_champ = 0;
        m_runs  = 0;
    endtask

    task automatic model_step(input logic st, input logic [1:0] mr, input logic [3:0] sd,
                              input logic w, input logic l, input logic g,
                              input logic [1:0] wh);
        int  nw, nl;
        bit  w_hit, l_hit;
        case (m_phase)
            PH_IDLE, PH_DONE: begin
                if (st) begin
                    m_phase = PH_LOAD;
                    m_mode  = mr;
                    m_iv    = int'(sd);
                    m_w     = 0;
                    m_l     = 0;
                    m_champ = 0;
                    m_runs  = 0;
                end
            end
            PH_LOAD: m_phase = PH_RUN;
            default: begin
                nw    = (m_w + int'(w) > MAX) ? MAX : m_w + int'(w);
                nl    = (m_l + int'(l) > MAX) ? MAX : m_l + int'(l);
                w_hit = (nw == MAX) && (m_w != MAX);
                l_hit = (nl == MAX) && (m_l != MAX);
                if (g) begin
                    m_phase = PH_DONE;
                    m_champ = int'(wh);
                end else if (w_hit || l_hit) begin
                    m_phase = PH_DONE;
                    m_champ = (w_hit && l_hit) ? 3 : (w_hit ? 2 : 1);
                end else begin
                    m_runs++;
                end
                m_w = nw;
                m_l = nl;
            end
        endcase
    endtask

    task automatic compare_all();
        int       flips;
        bit [1:0] exp_ctrl;
        flips    = m_runs / RC;
        exp_ctrl = {m_mode[1] ^ flips[0], m_mode[0]};
        check("ctrl_bus", 32'(ctrl_bus), 32'(exp_ctrl));
        check("init_value", 32'(init_value), 32'(m_iv));
        check("init", 32'(init), 32'(m_phase == PH_LOAD));
        check("win_tally", 32'(win_tally), 32'(m_w));
        check("lose_tally", 32'(lose_tally), 32'(m_l));
        check("busy", 32'(busy), 32'(m_phase == PH_LOAD || m_phase == PH_RUN));
        check("done", 32'(done), 32'(m_phase == PH_DONE));
        check("champion", 32'(champion), 32'(m_champ));
    endtask

    // Compare what the previous edge produced, then drive inputs for the next edge.
    task automatic cycle(input logic st, input logic [1:0] mr, input logic [3:0] sd,
                         input logic w, input logic l, input logic g, input logic [1:0] wh);
        @(negedge clk);
        compare_all();
        start    = st;
        mode_req = mr;
        seed     = sd;
        winner   = w;
        loser    = l;
        gameover = g;
        who      = wh;
        count    = 4'($urandom);
        model_step(st, mr, sd, w, l, g, wh);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    // Reset asserted mid-cycle must clear outputs before any further edge.
    task automatic mid_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        start    = 1'b0;
        winner   = 1'b0;
        loser    = 1'b0;
        gameover = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        mid_reset();
        idle_cycles(2);
        check("idle_busy", 32'(busy), 32'd0);

        // Game start with mode up2 and seed 5.
        cycle(1'b1, 2'b01, 4'd5, 1'b0, 1'b0, 1'b0, 2'b00);
        cycle(1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);
        check("start_ctrl", 32'(ctrl_bus), 32'd1);
        check("start_seed", 32'(init_value), 32'd5);
        check("start_init", 32'(init), 32'd1);
        cycle(1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);
        check("load_one_cycle", 32'(init), 32'd0);

        // Quiet running exercises two direction flips.
        idle_cycles(4);
        check("flip_first", 32'(ctrl_bus), 32'd3);
        idle_cycles(4);
        check("flip_back", 32'(ctrl_bus), 32'd1);

        // Mixed pulses then counter game over with who=10.
        cycle(1'b0, 2'b00, 4'd0, 1'b1, 1'b0, 1'b0, 2'b00);
        cycle(1'b0, 2'b00, 4'd0, 1'b0, 1'b1, 1'b0, 2'b00);
        cycle(1'b0, 2'b00, 4'd0, 1'b1, 1'b1, 1'b0, 2'b00);
        cycle(1'b0, 2'b00, 4'd0, 1'b1, 1'b0, 1'b0, 2'b00);
        cycle(1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b1, 2'b10);
        cycle(1'b0, 2'b00, 4'd0, 1'b1, 1'b0, 1'b0, 2'b00);
        check("go_champion", 32'(champion), 32'd2);
        check("go_win", 32'(win_tally), 32'd3);
        check("go_lose", 32'(lose_tally), 32'd2);
        check("go_busy", 32'(busy), 32'd0);
        cycle(1'b0, 2'b00, 4'd0, 1'b1, 1'b0, 1'b0, 2'b00);
        check("done_hold_win", 32'(win_tally), 32'd3);

        // Restart from DONE, then lose tally saturation.
        cycle(1'b1, 2'b10, 4'd9, 1'b0, 1'b0, 1'b0, 2'b00);
        cycle(1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);
        check("restart_win", 32'(win_tally), 32'd0);
        check("restart_champ", 32'(champion), 32'd0);
        check("restart_init", 32'(init), 32'd1);
        for (int i = 0; i < MAX; i++) cycle(1'b0, 2'b00, 4'd0, 1'b0, 1'b1, 1'b0, 2'b00);
        cycle(1'b0, 2'b00, 4'd0, 1'b0, 1'b1, 1'b0, 2'b00);
        check("sat_lose", 32'(lose_tally), 32'd15);
        check("sat_champ", 32'(champion), 32'd1);

        // Both tallies saturating on the same edge is a draw.
        cycle(1'b1, 2'b11, 4'd3, 1'b0, 1'b0, 1'b0, 2'b00);
        cycle(1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < MAX; i++) cycle(1'b0, 2'b00, 4'd0, 1'b1, 1'b1, 1'b0, 2'b00);
        cycle(1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);
        check("draw_champ", 32'(champion), 32'd3);

        // Gameover landing on a flip cycle must suppress the flip.
        cycle(1'b1, 2'b00, 4'd7, 1'b0, 1'b0, 1'b0, 2'b00);
        cycle(1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);
        idle_cycles(RC - 1);
        cycle(1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b1, 2'b01);
        cycle(1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);
        check("go_on_flip_ctrl", 32'(ctrl_bus), 32'd0);

        mid_reset();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                mid_reset();
            end else begin
                cycle($urandom_range(0, 99) < 20, 2'($urandom), 4'($urandom),
                      $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 25,
                      $urandom_range(0, 99) < 3, 2'($urandom));
            end
        end
        @(negedge clk);
        compare_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
